// File: rtl/io_input_ctrl_pkg.sv
// Shared IO register offsets. The SoC address decoder uses the same constants,
// so the peripheral and the decoder always agree on the map.
package io_input_ctrl_pkg;

  localparam logic [3:0] IO_OFS_SW     = 4'h0;
  localparam logic [3:0] IO_OFS_BTN    = 4'h4;
  localparam logic [3:0] IO_OFS_PRESS  = 4'h8;
  localparam logic [3:0] IO_OFS_STATUS = 4'hC;

  localparam logic [3:0] IO_OFS_MASK   = 4'hC;

endpackage

// File: rtl/io_input_ctrl_deb_sampler.sv
// Synchroniser, prescaler and sample/stable debouncer for a vector of raw levels.
// A bit of stable follows the input only after two consecutive ticks see the same value.
module deb_sampler #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 20000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [WIDTH-1:0] agree;

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    agree    = ~(sync2_q ^ samp_q);
    samp_d   = samp_q;
    stable_d = stable_q;
    if (tick) begin
      samp_d   = sync2_q;
      stable_d = (stable_q & ~agree) | (sync2_q & agree);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      samp_q   <= samp_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Debounced switch/button input block with a small register interface,
// press-event flags and a level interrupt.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int SW_W       = 24,
  parameter int BTN_W      = 5,
  parameter int DEB_CYCLES = 20000
) (
  input  logic             fpga_clk,
  input  logic             fpga_rst_n,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] button,
  input  logic             bus_rd,
  input  logic             bus_wr,
  input  logic [3:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  output logic             irq
);

  logic [SW_W-1:0]  sw_stable, sw_prev_q;
  logic [BTN_W-1:0] btn_stable, btn_prev_q;
  logic [BTN_W-1:0] press_flag_q, press_flag_d, press_clr;
  logic             sw_changed_q, sw_changed_d, chg_clr;
  logic [31:0]      rdata_q, rdata_d, rd_val;
  logic             ack_q, ack_d;
  logic             rd_hit, wr_hit;
  logic [3:0]       ofs;
  logic             unused_ok;

  deb_sampler #(.WIDTH(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
    .clk_i   (fpga_clk),
    .rst_ni  (fpga_rst_n),
    .raw_i   (sw),
    .stable_o(sw_stable)
  );

  deb_sampler #(.WIDTH(BTN_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk_i   (fpga_clk),
    .rst_ni  (fpga_rst_n),
    .raw_i   (button),
    .stable_o(btn_stable)
  );

  always_comb begin
    rd_hit = bus_rd;
    wr_hit = bus_wr & ~bus_rd;
    ofs    = bus_addr & IO_OFS_MASK;

    rd_val = '0;
    case (ofs)
      IO_OFS_SW:     rd_val = 32'(sw_stable);
      IO_OFS_BTN:    rd_val = 32'(btn_stable);
      IO_OFS_PRESS:  rd_val = 32'(press_flag_q);
      IO_OFS_STATUS: rd_val = {31'b0, sw_changed_q};
      default:       rd_val = '0;
    endcase

    // Read-to-clear only drops the bits that the read actually returned.
    press_clr = '0;
    chg_clr   = 1'b0;
    if (rd_hit) begin
      if (ofs == IO_OFS_PRESS)  press_clr = press_flag_q;
      if (ofs == IO_OFS_STATUS) chg_clr   = sw_changed_q;
    end else if (wr_hit && ofs == IO_OFS_PRESS) begin
      press_clr = bus_wdata[BTN_W-1:0];
    end

    press_flag_d = (press_flag_q & ~press_clr) | (btn_stable & ~btn_prev_q);
    sw_changed_d = (sw_changed_q & ~chg_clr) | (sw_stable != sw_prev_q);

    ack_d   = rd_hit | wr_hit;
    rdata_d = rd_hit ? rd_val : rdata_q;
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sw_prev_q    <= '0;
      btn_prev_q   <= '0;
      press_flag_q <= '0;
      sw_changed_q <= 1'b0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      sw_prev_q    <= sw_stable;
      btn_prev_q   <= btn_stable;
      press_flag_q <= press_flag_d;
      sw_changed_q <= sw_changed_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign irq       = |press_flag_q;

  assign unused_ok = ^{bus_wdata[31:BTN_W], bus_addr[1:0]};

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 24, switch count.
REQ-002 SHALL have parameter BTN_W, default 5, button count.
REQ-003 SHALL have parameter DEB_CYCLES, default 20000, clock cycles per debounce sample tick (minimum 2).
REQ-004 SHALL have port fpga_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port fpga_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port sw  input  SW_W  raw asynchronous switch levels.
REQ-007 SHALL have port button  input  BTN_W  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port bus_rd  input  1  read strobe, one cycle per access.
REQ-009 SHALL have port bus_wr  input  1  write strobe, one cycle per access.
REQ-010 SHALL have port bus_addr  input  4  byte offset; bits [1:0] ignored.
REQ-011 SHALL have port bus_wdata  input  32  write data.
REQ-012 SHALL have port bus_rdata  output  32  registered read data.
REQ-013 SHALL have port bus_ack  output  1  one-cycle access-complete pulse.
REQ-014 SHALL have port irq  output  1  OR of pending press flags.

Function
REQ-015 SHALL pass sw and button through a 2-flop synchroniser before any other use.
REQ-016 SHALL run a prescaler counting 0..DEB_CYCLES-1 and wrapping to 0, asserting tick in the cycle where the count equals DEB_CYCLES-1.
REQ-017 SHALL, on each tick, load samp from the synchronised inputs and load stable bit-wise from the synchronised inputs wherever they equal samp.
REQ-018 SHALL make a synchronised change lasting at least 2*DEB_CYCLES cycles appear in stable within 2*DEB_CYCLES cycles.
REQ-019 SHALL never change stable for a pulse shorter than DEB_CYCLES-1 cycles.
REQ-020 SHALL set press_flag[i] in the cycle after stable button bit i goes 0->1; 1->0 sets nothing.
REQ-021 SHALL use this register map: 0x0 = stable sw zero-extended (RO); 0x4 = stable button zero-extended (RO); 0x8 = press_flag (read-to-clear, write-1-to-clear); 0xC = bit0 sw_changed, sticky, set on any stable sw change, read-to-clear.
REQ-022 SHALL return rdata 0 and ack for unmapped reads, and ignore writes to offsets other than 0x8 while still acking.
REQ-023 SHALL register bus_rdata and bus_ack one cycle after the strobe, and hold bus_rdata until the next read.
REQ-024 SHALL, on read-to-clear, clear only the bits returned in that read's data.
REQ-025 SHALL let a set take precedence when a flag set and a clear (read or W1C) hit the same bit in the same cycle, so the flag stays 1.
REQ-026 SHALL treat bus_rd and bus_wr asserted together as a read only.
REQ-027 SHALL drive irq combinationally as |press_flag, with no other latency.

Reset
REQ-028 SHALL, while fpga_rst_n=0, clear the synchronisers, samp, stable, prescaler, press_flag and sw_changed, and drive bus_rdata=0, bus_ack=0 and irq=0.
REQ-029 SHALL discard any access in flight when reset asserts, with no ack after release.
REQ-030 SHALL restart the prescaler from 0 on reset release, so the first tick falls DEB_CYCLES cycles later.

Structure
REQ-031 SHALL take its register offsets (0x0, 0x4, 0x8, 0xC) from the shared io package constants, also used by the SoC address decoder.
REQ-032 SHALL place synchroniser, prescaler and sample/stable logic in one sub-module, deb_sampler, parameterised by width and DEB_CYCLES, instantiated twice (sw, button).

Verification (DEB_CYCLES=4)
REQ-033 SHALL verify: reset, sw=24'h000003 held 20 cycles, read 0x0 -> rdata=32'h3 one cycle after strobe, ack one cycle wide.
REQ-034 SHALL verify: button[2] glitch of 2 cycles -> stable button remains 0, press_flag=0, irq=0.
REQ-035 SHALL verify: button[0] held 12 cycles -> irq=1; read 0x8 -> rdata=32'h1; next read 0x8 -> 0; irq=0.
REQ-036 SHALL verify: press_flag[1] set in the same cycle as a read-to-clear of 0x8 -> flag still 1 afterwards.
REQ-037 SHALL verify: flags 5'b00011, write 0x8 with 32'h1 -> flags 5'b00010.
REQ-038 SHALL verify: fpga_rst_n dropped mid-read -> bus_ack never pulses, all outputs 0; after release a read of 0xC returns 0.
